shift_ring_counter: RTL and testbench

- Parametrised ring/Johnson shift counter; next generation of the board's LED ring counter.
- Single clock domain: an internal prescaler produces a step enable, replacing the divided-clock scheme.
- Adds width and prescale parameters, ring/Johnson mode, up/down direction, run/pause, parallel load, self-correction of illegal states, and step/wrap/fault status.
- Drives LED banks or sequencing strobes directly from the top level.

---
 rtl/shift_counter_pkg.sv | 41 ++++
 rtl/tick_prescaler.sv | 31 +++
 rtl/shift_ring_counter.sv | 82 ++++++++
 tb/tb_shift_ring_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_counter_pkg.sv
// Shared constants and legality helpers for the ring/Johnson shift counter.
// Vectors are passed zero-extended to 32 bits, with the live width as an argument.
package shift_counter_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DOWN     = 1'b1;

   // Ring home is a single one in bit 0; Johnson home is all zeros.
   function automatic logic [31:0] home_state(input logic mode, input int width);
      home_state = '0;
      if (mode == MODE_RING && width > 0) begin
         home_state[0] = 1'b1;
      end
   endfunction

   function automatic logic is_onehot(input logic [31:0] v, input int width);
      int ones;
      ones = 0;
      for (int i = 0; i < 32; i++) begin
         if (i < width && v[i]) begin
            ones++;
         end
      end
      return ones == 1;
   endfunction

   // A Johnson code is a run of ones anchored at either end: at most one bit-to-bit change.
   function automatic logic is_johnson(input logic [31:0] v, input int width);
      int edges;
      edges = 0;
      for (int i = 0; i < 31; i++) begin
         if (i + 1 < width && v[i] != v[i+1]) begin
            edges++;
         end
      end
      return edges <= 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: one-cycle tick every PRESCALE enabled cycles.
// clr restarts the period; a paused (en = 0) counter keeps its phase.
module tick_prescaler #(
   parameter int PRESCALE = 20000000
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] pcnt;

   assign tick = en && (pcnt == LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         pcnt <= '0;
      end else if (clr || tick) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= pcnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/shift_ring_counter.sv
// Parametrised ring/Johnson shift counter with prescaled stepping, load,
// self-correction of illegal states and registered step/wrap/fault status.
module shift_ring_counter
   import shift_counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 20000000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q,
   output logic             step,
   output logic             wrap,
   output logic             fault
);

   logic             tick;
   logic [31:0]      q_ext;
   logic [WIDTH-1:0] home;
   logic [WIDTH-1:0] shifted;
   logic             legal;

   // A load also restarts the period, so a tick coinciding with it is dropped.
   tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clock (clock),
      .reset (reset),
      .en    (run),
      .clr   (load),
      .tick  (tick)
   );

   // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
   always_comb begin
      q_ext            = '0;
      q_ext[WIDTH-1:0] = q;
      home             = WIDTH'(home_state(mode, WIDTH));
      legal            = (mode == MODE_RING) ? is_onehot(q_ext, WIDTH)
                                             : is_johnson(q_ext, WIDTH);
      shifted          = q;
      case ({mode, dir})
         {MODE_RING,    DIR_UP}:   shifted = {q[WIDTH-2:0], q[WIDTH-1]};
         {MODE_RING,    DIR_DOWN}: shifted = {q[0], q[WIDTH-1:1]};
         {MODE_JOHNSON, DIR_UP}:   shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
         {MODE_JOHNSON, DIR_DOWN}: shifted = {~q[0], q[WIDTH-1:1]};
         default:                  shifted = q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q     <= home;
         step  <= 1'b0;
         wrap  <= 1'b0;
         fault <= 1'b0;
      end else if (load) begin
         q     <= seed;
         step  <= 1'b0;
         wrap  <= 1'b0;
         fault <= 1'b0;
      end else if (tick) begin
         step <= 1'b1;
         if (legal) begin
            q    <= shifted;
            wrap <= (shifted == home);
         end else begin
            // Correction replaces the shift and never counts as a wrap.
            q     <= home;
            wrap  <= 1'b0;
            fault <= 1'b1;
         end
      end else begin
         step <= 1'b0;
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Self-checking bench for shift_ring_counter (WIDTH = 4, PRESCALE = 3): directed
// scenarios pinned to literal values, then randomized stimulus against a sequence-table model.
module tb_shift_ring_counter;

   localparam int WIDTH    = 4;
   localparam int PRESCALE = 3;

   bit               clock;
   logic             reset = 1'b1;
   logic             run   = 1'b0;
   logic             mode  = 1'b0;
   logic             dir   = 1'b0;
   logic             load  = 1'b0;
   logic [WIDTH-1:0] seed  = '0;
   logic [WIDTH-1:0] q;
   logic             step;
   logic             wrap;
   logic             fault;

   shift_ring_counter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .mode  (mode),
      .dir   (dir),
      .load  (load),
      .seed  (seed),
      .q     (q),
      .step  (step),
      .wrap  (wrap),
      .fault (fault)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: position within the legal code sequence, plus run-cycle phase.
   int mq;
   bit mstep, mwrap, mfault;
   int ph;

   bit         pin_en = 1'b0;
   logic [6:0] pin_word = '0;
   string      pin_name = "";

   function automatic void advance(input int cur, input bit jmode, input bit down,
                                   output int nxt, output bit wr, output bit ft);
      int seq[8];
      int n;
      int idx;
      int ni;
      if (jmode) begin
         seq = '{0, 1, 3, 7, 15, 14, 12, 8};
         n   = 8;
      end else begin
         seq = '{1, 2, 4, 8, 0, 0, 0, 0};
         n   = 4;
      end
      idx = -1;
      for (int i = 0; i < n; i++) begin
         if (seq[i] == cur) idx = i;
      end
      if (idx < 0) begin
         nxt = jmode ? 0 : 1;
         wr  = 1'b0;
         ft  = 1'b1;
      end else begin
         ni  = down ? (idx + n - 1) % n : (idx + 1) % n;
         nxt = seq[ni];
         wr  = (ni == 0);
         ft  = 1'b0;
      end
   endfunction

   always @(posedge clock) begin
      int nq;
      bit wr;
      bit ft;
      if (reset) begin
         mq     <= mode ? 0 : 1;
         ph     <= 0;
         mstep  <= 1'b0;
         mwrap  <= 1'b0;
         mfault <= 1'b0;
      end else if (load) begin
         mq     <= int'(seed);
         ph     <= 0;
         mstep  <= 1'b0;
         mwrap  <= 1'b0;
         mfault <= 1'b0;
      end else if (run && ph == PRESCALE - 1) begin
         advance(mq, mode, dir, nq, wr, ft);
         mq    <= nq;
         ph    <= 0;
         mstep <= 1'b1;
         mwrap <= wr;
         if (ft) mfault <= 1'b1;
      end else begin
         if (run) ph <= ph + 1;
         mstep <= 1'b0;
         mwrap <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      check("q",     32'(q),     32'(mq));
      check("step",  32'(step),  32'(mstep));
      check("wrap",  32'(wrap),  32'(mwrap));
      check("fault", 32'(fault), 32'(mfault));
      if (pin_en) begin
         check({pin_name, "_model"}, {25'd0, 4'(mq), mstep, mwrap, mfault}, {25'd0, pin_word});
         check({pin_name, "_dut"},   {25'd0, q, step, wrap, fault},         {25'd0, pin_word});
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic pin(input logic [3:0] eq, input logic es, input logic ew, input logic ef,
                      input string nm);
      pin_word = {eq, es, ew, ef};
      pin_name = nm;
      pin_en   = 1'b1;
      @(negedge clock);
      #1;
      pin_en = 1'b0;
   endtask

   logic [3:0] jexp[8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                           4'b1110, 4'b1100, 4'b1000, 4'b0000};

   initial begin
      // Ring up, full revolution
      reset = 1'b1; mode = 1'b0; dir = 1'b0; run = 1'b1;
      pin(4'b0001, 0, 0, 0, "reset_ring");
      reset = 1'b0;
      wait_cyc(2); pin(4'b0010, 1, 0, 0, "ring_1");
      wait_cyc(2); pin(4'b0100, 1, 0, 0, "ring_2");
      wait_cyc(2); pin(4'b1000, 1, 0, 0, "ring_3");
      wait_cyc(2); pin(4'b0001, 1, 1, 0, "ring_wrap");

      // Johnson up, full sequence
      mode = 1'b1; reset = 1'b1;
      pin(4'b0000, 0, 0, 0, "reset_john");
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_cyc(2); pin(jexp[k], 1, (k == 7), 0, "john_seq");
      end

      // Johnson direction reversal from 0111
      reset = 1'b1;
      pin(4'b0000, 0, 0, 0, "reset_john2");
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_cyc(2); pin(jexp[k], 1, 0, 0, "john_seq2");
      end
      dir = 1'b1;
      wait_cyc(2); pin(4'b0011, 1, 0, 0, "john_down");

      // Illegal ring seed corrected, then a fresh load clears fault
      mode = 1'b0; dir = 1'b0; reset = 1'b1;
      pin(4'b0001, 0, 0, 0, "reset_ring2");
      reset = 1'b0; load = 1'b1; seed = 4'b0110;
      pin(4'b0110, 0, 0, 0, "load_bad");
      load = 1'b0;
      wait_cyc(2); pin(4'b0001, 1, 0, 1, "ring_fault");
      load = 1'b1; seed = 4'b0100;
      pin(4'b0100, 0, 0, 0, "load_clr");
      load = 1'b0;
      wait_cyc(2); pin(4'b1000, 1, 0, 0, "after_load");

      // Pause mid-period keeps the phase
      wait_cyc(1);
      run = 1'b0;
      wait_cyc(9); pin(4'b1000, 0, 0, 0, "paused");
      run = 1'b1;
      wait_cyc(1); pin(4'b0001, 1, 1, 0, "resume_partial");

      // Load on the exact tick cycle
      wait_cyc(2);
      load = 1'b1; seed = 4'b1000;
      pin(4'b1000, 0, 0, 0, "load_on_tick");
      load = 1'b0;
      wait_cyc(2); pin(4'b0001, 1, 1, 0, "post_load_wrap");

      // Reset mid-period discards the phase
      wait_cyc(2); pin(4'b0010, 1, 0, 0, "pre_reset_a");
      wait_cyc(2); pin(4'b0100, 1, 0, 0, "pre_reset_b");
      wait_cyc(1);
      reset = 1'b1;
      pin(4'b0001, 0, 0, 0, "mid_reset");
      reset = 1'b0;
      wait_cyc(2); pin(4'b0010, 1, 0, 0, "post_reset_step");

      // Illegal Johnson seed, then a mode switch that makes 0000 illegal
      wait_cyc(2);
      mode = 1'b1; load = 1'b1; seed = 4'b0101;
      pin(4'b0101, 0, 0, 0, "load_bad_john");
      load = 1'b0;
      wait_cyc(2); pin(4'b0000, 1, 0, 1, "john_fault");
      mode = 1'b0;
      wait_cyc(2); pin(4'b0001, 1, 0, 1, "mode_switch_fix");

      // Randomized stimulus against the model
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(63) == 0);
         load  = ($urandom_range(15) == 0);
         run   = ($urandom_range(7) != 0);
         if ($urandom_range(31) == 0) mode = ~mode;
         if ($urandom_range(15) == 0) dir = ~dir;
         seed = 4'($urandom);
         wait_cyc(1);
      end
      reset = 1'b0; load = 1'b0;
      wait_cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
